// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared state type, LFSR/MISR tap constants and MISR step function for the gate BIST controller
package gate_bist_pkg;
  localparam int SIG_W = 16;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;
  localparam logic [SIG_W-1:0] MISR_TAPS = 16'hB400;
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s, input logic [SIG_W-1:0] d);
    return {s[SIG_W-2:0], ^(s & MISR_TAPS)} ^ d;
  endfunction
endpackage

// File: rtl/gate_bist_misr.sv
// gate_bist_misr: 16-bit MISR compacting a parallel OUT_W-bit response, with clear and enable
module gate_bist_misr
  import gate_bist_pkg::*;
#(
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [SIG_W-1:0] sig
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig <= '0;
    else if (clr) sig <= '0;
    else if (en) sig <= misr_next(sig, SIG_W'(din));
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: BIST sequencer driving stimulus into a gate model and signing its responses.
// GATE_BIST_EXHAUSTIVE_EN swaps the LFSR for a binary counter covering all 2^IN_W patterns.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int              IN_W       = 15,
  parameter int              OUT_W      = 10,
  parameter int              NUM_PAT    = 256,
  parameter int              SETTLE_CYC = 2,
  parameter logic [IN_W-1:0] SEED       = 15'h0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] exp_sig,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      pat_cnt
);
  localparam logic [15:0] settle_last = 16'(SETTLE_CYC - 1);
`ifdef GATE_BIST_EXHAUSTIVE_EN
  localparam logic [16:0] last = 17'((1 << IN_W) - 1);
  localparam logic [IN_W-1:0] load = '0;
`else
  localparam logic [16:0] last = 17'(NUM_PAT - 1);
  localparam logic [IN_W-1:0] load = (SEED == '0) ? IN_W'(1) : SEED;
`endif
  state_t state;
  logic [IN_W-1:0] lfsr;
  logic [IN_W-1:0] lfsr_nxt;
  logic [16:0] cnt;
  logic [15:0] settle_cnt;
  logic go;
  logic cap;
  assign go = start && (state == IDLE || state == DONE);
  assign cap = state == CAPTURE;
`ifdef GATE_BIST_EXHAUSTIVE_EN
  assign lfsr_nxt = lfsr + IN_W'(1);
`else
  assign lfsr_nxt = {lfsr[IN_W-2:0], ^(lfsr & IN_W'(LFSR_TAPS))};
`endif
  gate_bist_misr #(.OUT_W(OUT_W)) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (go),
    .en   (cap),
    .din  (dut_out),
    .sig  (signature)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= '0;
      cnt        <= '0;
      settle_cnt <= '0;
    end else if (go) begin
      state      <= SETTLE;
      lfsr       <= load;
      cnt        <= '0;
      settle_cnt <= '0;
    end else if (state == SETTLE) begin
      state      <= (settle_cnt == settle_last) ? CAPTURE : SETTLE;
      settle_cnt <= (settle_cnt == settle_last) ? '0 : settle_cnt + 16'd1;
    end else if (cap) begin
      lfsr  <= lfsr_nxt;
      cnt   <= cnt + 17'd1;
      state <= (cnt == last) ? DONE : SETTLE;
    end
  end
  assign dut_in  = lfsr;
  assign busy    = state == SETTLE || state == CAPTURE;
  assign done    = state == DONE;
  assign pass    = done && signature == exp_sig;
  assign pat_cnt = cnt[15:0];
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: randomized self-checking bench with a time-based reference model of the BIST run
module tb_gate_bist_ctrl;
`ifdef GATE_BIST_EXHAUSTIVE_EN
  localparam int SC = 1;
  localparam int TOTAL = 1 << 15;
`else
  localparam int SC = 2;
  localparam int TOTAL = 4;
`endif
  localparam int NP = 4;
  logic clk = 0, rst_n = 0, start = 0;
  logic [15:0] exp_sig = 0;
  logic [9:0] dut_out = 0;
  logic [14:0] dut_in;
  logic busy, done, pass;
  logic [15:0] signature, pat_cnt;
  int n_chk = 0, n_fail = 0;
  bit en = 0;
  bit m_run = 0, m_done = 0;
  int m_t = 0, m_k = 0;
  logic [14:0] m_stim = 0;
  logic [15:0] m_sig = 0;
  always #5 clk = ~clk;
  gate_bist_ctrl #(.IN_W(15), .OUT_W(10), .NUM_PAT(NP), .SETTLE_CYC(SC), .SEED(15'h0001)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_sig(exp_sig), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .pat_cnt(pat_cnt)
  );
  function automatic logic [14:0] stim_next(input logic [14:0] s);
`ifdef GATE_BIST_EXHAUSTIVE_EN
    return s + 15'd1;
`else
    return {s[13:0], s[14] ^ s[13]};
`endif
  endfunction
  function automatic logic [14:0] stim_first();
`ifdef GATE_BIST_EXHAUSTIVE_EN
    return 15'd0;
`else
    return 15'd1;
`endif
  endfunction
  // Model: a run is SC+1 cycles per pattern counted from the start edge; a capture lands on every multiple.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_t = 0; m_k = 0; m_stim = 0; m_sig = 0;
    end else if (!m_run && start) begin
      m_run = 1; m_done = 0; m_t = 0; m_k = 0; m_stim = stim_first(); m_sig = 0;
    end else if (m_run) begin
      m_t++;
      if (m_t % (SC + 1) == 0) begin
        m_sig = {m_sig[14:0], m_sig[15] ^ m_sig[13] ^ m_sig[12] ^ m_sig[10]} ^ {6'd0, dut_out};
        m_stim = stim_next(m_stim);
        m_k++;
        if (m_k == TOTAL) begin m_run = 0; m_done = 1; end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask
  always @(posedge clk) begin
    #2;
    if (en) begin
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("pass", pass, m_done && m_sig == exp_sig);
      chk("dut_in", dut_in, m_stim);
      chk("signature", signature, m_sig);
      chk("pat_cnt", pat_cnt, 16'(m_k));
    end
  end
  task automatic wait_done(input int lim);
    int i = 0;
    while (!done && i < lim) begin @(negedge clk); i++; end
    chk("done_timeout", done, 1);
  endtask
  task automatic wait_pat(input logic [15:0] v, input int lim);
    int i = 0;
    while (pat_cnt != v && i < lim) begin @(negedge clk); i++; end
    chk("pat_timeout", pat_cnt, v);
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_dut_in"}, dut_in, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass, 0);
    chk({nm, "_sig"}, signature, 0);
    chk({nm, "_pat"}, pat_cnt, 0);
  endtask
  initial begin
    logic [14:0] tbl [13] = '{15'h1, 15'h1, 15'h1, 15'h2, 15'h2, 15'h2, 15'h4, 15'h4, 15'h4, 15'h8, 15'h8, 15'h8, 15'h10};
    int cyc;
    repeat (3) @(negedge clk);
    en = 1;
    chk_zero("reset");
    rst_n = 1;
    @(negedge clk);
`ifdef GATE_BIST_EXHAUSTIVE_EN
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 1;
    while (!done && cyc < 70000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 65535) chk("exh_last_stim", dut_in, 15'h7FFF);
    end
    chk("exh_latency", cyc, 32768 * 2 + 1);
    chk("exh_pat_cnt", pat_cnt, 16'h8000);
    chk("exh_dut_in_wrap", dut_in, 0);
`else
    start = 1;
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      if (j == 0) start = 0;
      chk("seq_dut_in", dut_in, tbl[j]);
      chk("seq_done", done, 32'(j == 12));
    end
    chk("seq_sig", signature, 0);
    chk("seq_pass", pass, 1);
    dut_out = 10'h001;
    exp_sig = 16'h0003;
    pulse_start();
    wait_pat(16'd1, 20);
    chk("misr_p1", signature, 16'h0001);
    wait_pat(16'd2, 20);
    chk("misr_p2", signature, 16'h0003);
    wait_done(40);
    chk("misr_final", signature, 16'h000F);
    chk("misr_pass_bad", pass, 0);
    exp_sig = 16'h000F;
    @(negedge clk);
    chk("misr_pass_good", pass, 1);
    dut_out = 0;
    start = 1;
    wait_done(60);
    @(negedge clk);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_sig", signature, 0);
    chk("restart_pat", pat_cnt, 0);
    start = 0;
    wait_done(60);
    pulse_start();
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_done", done, 0);
    for (int r = 0; r < 25; r++) begin
      exp_sig = 16'($urandom);
      int_loop: for (int c = 0; c < 20 + $urandom_range(0, 20); c++) begin
        dut_out = 10'($urandom);
        start = $urandom_range(0, 3) == 0;
        rst_n = $urandom_range(0, 80) != 0;
        if (m_done && $urandom_range(0, 1) == 1) exp_sig = m_sig;
        @(negedge clk);
      end
      rst_n = 1;
    end
    start = 0;
    pulse_start();
    wait_done(60);
    repeat (3) @(negedge clk);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
